// File: rtl/print_line_streamer.sv
// print_line_streamer: buffers completed print lines in a small FIFO and
// sends each one to the host as a byte packet: SYNC_BYTE, an 8-bit sequence
// number, then the line bytes MSB-first. Lines that arrive while the FIFO is
// full are dropped and counted in a saturating 16-bit counter.
//
// Stream handshake: a beat transfers on a rising edge where out_valid and
// out_ready are both 1; while out_valid=1 and out_ready=0, out_data and
// out_last hold, and out_valid never drops until its beat has transferred.
module print_line_streamer #(
    parameter int         HEAD_WIDTH = 384,
    parameter int         LINE_DEPTH = 4,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              print_line_ready,
    input  logic [HEAD_WIDTH-1:0]             print_line,
    input  logic                              out_ready,
    output logic                              out_valid,
    output logic [7:0]                        out_data,
    output logic                              out_last,
    output logic [$clog2(LINE_DEPTH+1)-1:0]   lines_pending,
    output logic [15:0]                       overflow_count
);
    localparam int LINE_BYTES = HEAD_WIDTH / 8;
    localparam int PTR_W      = $clog2(LINE_DEPTH);
    localparam int CNT_W      = $clog2(LINE_DEPTH + 1);
    localparam int IDX_W      = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;

    typedef enum logic [1:0] {IDLE, SYNC, SEQ, DATA} state_t;

    state_t                state_q;
    logic [HEAD_WIDTH-1:0] mem_q [LINE_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic [7:0]            seq_q;
    logic [IDX_W-1:0]      idx_q;
    logic [15:0]           ovf_q;
    logic                  out_valid_q;
    logic [7:0]            out_data_q;
    logic                  out_last_q;

    logic                  xfer;
    logic                  pop;
    logic                  full;
    logic                  push;
    logic                  drop;
    logic [HEAD_WIDTH-1:0] head_line;
    logic [IDX_W-1:0]      next_idx;
    int                    sel_idx;
    int                    shamt;
    logic [7:0]            next_byte;

    // Handshake, push/pop decisions and the next line byte to present.
    always_comb begin
        xfer = out_valid_q && out_ready;
        // The slot frees only when the final beat actually transfers.
        pop  = xfer && (state_q == DATA) && (idx_q == IDX_W'(LINE_BYTES - 1));
        full = (count_q == CNT_W'(LINE_DEPTH));
        // A full FIFO still takes a line on the edge that frees a slot.
        push = print_line_ready && (!full || pop);
        drop = print_line_ready && !push;
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        head_line = mem_q[rd_ptr_q];
        next_idx  = (state_q == DATA) ? idx_q + 1'b1 : '0;
        // Past the last byte the selection is unused; clamp to stay in range.
        sel_idx   = (int'(next_idx) < LINE_BYTES) ? int'(next_idx) : 0;
        shamt     = 8 * (LINE_BYTES - 1 - sel_idx);
        next_byte = 8'(head_line >> shamt);
    end

    // Line storage: write the captured line into the tail slot.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= print_line;
        end
    end

    // FIFO pointers, occupancy and the saturating drop counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            if (drop && (ovf_q != 16'hFFFF)) ovf_q <= ovf_q + 16'd1;
        end
    end

    // Packet FSM with registered stream outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            seq_q       <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (count_q != '0) begin
                        state_q     <= SYNC;
                        out_valid_q <= 1'b1;
                        out_data_q  <= SYNC_BYTE;
                        out_last_q  <= 1'b0;
                    end
                end
                SYNC: begin
                    if (xfer) begin
                        state_q    <= SEQ;
                        out_data_q <= seq_q;
                    end
                end
                SEQ: begin
                    if (xfer) begin
                        state_q    <= DATA;
                        idx_q      <= '0;
                        out_data_q <= next_byte;
                        out_last_q <= (LINE_BYTES == 1);
                    end
                end
                DATA: begin
                    if (xfer) begin
                        if (pop) begin
                            seq_q      <= seq_q + 8'd1;
                            idx_q      <= '0;
                            out_last_q <= 1'b0;
                            // Lines still waiting start immediately, no idle gap.
                            if (count_d != '0) begin
                                state_q    <= SYNC;
                                out_data_q <= SYNC_BYTE;
                            end else begin
                                state_q     <= IDLE;
                                out_valid_q <= 1'b0;
                                out_data_q  <= '0;
                            end
                        end else begin
                            idx_q      <= next_idx;
                            out_data_q <= next_byte;
                            out_last_q <= (int'(next_idx) == LINE_BYTES - 1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign out_last       = out_last_q;
    assign lines_pending  = count_q;
    assign overflow_count = ovf_q;

endmodule

// File: tb/tb_print_line_streamer.sv
// Bench for print_line_streamer: directed scenarios plus random traffic,
// checked by a line-level reference model feeding an expected byte queue.
module tb_print_line_streamer;
    localparam int HW    = 384;
    localparam int DEPTH = 4;
    localparam int LB    = HW / 8;
    localparam int CW    = $clog2(DEPTH + 1);

    // Clock / reset and DUT signals
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          print_line_ready = 1'b0;
    logic [HW-1:0] print_line = '0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [7:0]    out_data;
    logic          out_last;
    logic [CW-1:0] lines_pending;
    logic [15:0]   overflow_count;

    always #5 clk = ~clk;

    print_line_streamer #(
        .HEAD_WIDTH(HW),
        .LINE_DEPTH(DEPTH),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .print_line_ready(print_line_ready),
        .print_line      (print_line),
        .out_ready       (out_ready),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .out_last        (out_last),
        .lines_pending   (lines_pending),
        .overflow_count  (overflow_count)
    );

    // Scoreboard state: expected beats are {last, data}
    logic [8:0]  exp_q[$];
    int          n_vec = 0;
    int          n_fail = 0;
    int          m_count = 0;
    logic [7:0]  m_seq = '0;
    logic [15:0] m_ovf = '0;
    bit          mon_en = 1'b0;
    bit          gap_chk = 1'b0;
    bit          p_stall = 1'b0;
    logic [7:0]  p_data = '0;
    logic        p_last = 1'b0;
    int          xfer_cnt = 0;
    int          pkt_cnt = 0;
    logic [8:0]  e;
    bit          m_pop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [HW-1:0] rand_line();
        logic [HW-1:0] l;
        for (int i = 0; i < HW / 32; i++) l[i*32 +: 32] = $urandom();
        return l;
    endfunction

    // Reference: a packet is the sync byte, the sequence number, then the
    // line cut into bytes from the most significant end.
    function automatic void push_pkt(input logic [HW-1:0] line, input logic [7:0] seq);
        logic [7:0] b;
        exp_q.push_back({1'b0, 8'hA5});
        exp_q.push_back({1'b0, seq});
        for (int k = 0; k < LB; k++) begin
            b = 8'(line >> (8 * (LB - 1 - k)));
            exp_q.push_back({(k == LB - 1), b});
        end
    endfunction

    // Monitor: samples on the falling edge what the next rising edge will do
    always @(negedge clk) begin
        if (mon_en) begin
            chk("lines_pending", 32'(lines_pending), 32'(m_count));
            chk("overflow_count", 32'(overflow_count), 32'(m_ovf));
            if (gap_chk) chk("no_idle_gap", 32'(out_valid), 32'd1);
            gap_chk = 1'b0;
            if (p_stall) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", 32'(out_data), 32'(p_data));
                chk("stall_last", 32'(out_last), 32'(p_last));
            end
            m_pop = 1'b0;
            if (reset) begin
                exp_q.delete();
                m_count = 0;
                m_seq   = '0;
                m_ovf   = '0;
            end else begin
                if (out_valid && out_ready) begin
                    xfer_cnt++;
                    if (out_last) pkt_cnt++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", {23'd0, out_last, out_data}, 32'h1FF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", 32'(out_data), 32'(e[7:0]));
                        chk("beat_last", 32'(out_last), 32'(e[8]));
                        m_pop = e[8];
                    end
                end
                if (print_line_ready) begin
                    if (m_count < DEPTH || m_pop) begin
                        push_pkt(print_line, m_seq);
                        m_seq = m_seq + 8'd1;
                        m_count++;
                    end else if (m_ovf != 16'hFFFF) begin
                        m_ovf = m_ovf + 16'd1;
                    end
                end
                if (m_pop) m_count--;
                if (m_pop && m_count > 0) gap_chk = 1'b1;
            end
            p_stall = out_valid && !out_ready && !reset;
            p_data  = out_data;
            p_last  = out_last;
        end
    end

    // Driver tasks
    task automatic reset_pulse();
        @(posedge clk); #2; reset = 1'b1;
        @(posedge clk); #2; reset = 1'b0;
    endtask

    task automatic pulse(input logic [HW-1:0] line);
        @(posedge clk); #2; print_line = line; print_line_ready = 1'b1;
        @(posedge clk); #2; print_line_ready = 1'b0;
    endtask

    // mode 0: ready high; 1: toggle with one 20-cycle stall; 2: random
    task automatic drain(input int mode, input int budget);
        int cyc = 0;
        int st  = int'($urandom_range(5, 40));
        while (m_count != 0 || exp_q.size() != 0) begin
            if (cyc >= budget) begin
                chk("drain_timeout", 32'(exp_q.size()), 32'd0);
                break;
            end
            @(posedge clk); #2;
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = (cyc >= st && cyc < st + 20) ? 1'b0 : cyc[0];
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            cyc++;
        end
    endtask

    task automatic wait_room(input int budget);
        int cyc = 0;
        while (m_count >= DEPTH && cyc < budget) begin
            @(posedge clk); #2;
            cyc++;
        end
        if (cyc >= budget) chk("room_timeout", 32'(m_count), 32'(DEPTH - 1));
    endtask

    // Stimulus
    logic [HW-1:0] ramp;
    int            base;
    int            cyc;

    initial begin
        for (int i = 0; i < LB; i++) ramp[HW-1-8*i -: 8] = 8'(i);

        // Reset state
        repeat (3) @(posedge clk);
        #2; reset = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_pending", 32'(lines_pending), 32'd0);
        chk("rst_ovf", 32'(overflow_count), 32'd0);

        // Single line, ramp pattern, latency of two cycles
        out_ready = 1'b1;
        pulse(ramp);
        @(negedge clk);
        chk("latency_t1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("latency_t2_valid", 32'(out_valid), 32'd1);
        chk("latency_t2_sync", 32'(out_data), 32'hA5);
        drain(0, 200);
        @(negedge clk);
        chk("idle_after", 32'(out_valid), 32'd0);

        // Backpressure on the same line
        out_ready = 1'b0;
        pulse(ramp);
        drain(1, 400);

        // Overflow: five lines into four slots
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) pulse(rand_line());
        @(negedge clk);
        chk("ovf_pending", 32'(lines_pending), 32'd4);
        chk("ovf_count", 32'(overflow_count), 32'd1);
        drain(0, 400);

        // Full FIFO, push coincides with the out_last transfer
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) pulse(rand_line());
        @(posedge clk); #2; out_ready = 1'b1;
        cyc = 0;
        while (!(out_valid && out_last) && cyc < 200) begin
            @(posedge clk); #2;
            cyc++;
        end
        chk("collide_found_last", 32'(out_valid && out_last), 32'd1);
        print_line = rand_line();
        print_line_ready = 1'b1;
        @(posedge clk); #2; print_line_ready = 1'b0;
        @(negedge clk);
        chk("collide_pending", 32'(lines_pending), 32'd4);
        chk("collide_ovf", 32'(overflow_count), 32'd1);
        drain(0, 600);

        // Random traffic with random backpressure
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #2;
            print_line       = rand_line();
            print_line_ready = ($urandom_range(0, 7) == 0);
            out_ready        = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #2; print_line_ready = 1'b0;
        drain(2, 2000);

        // Sequence wrap: 257 accepted lines
        reset_pulse();
        out_ready = 1'b1;
        base = pkt_cnt;
        for (int i = 0; i < 257; i++) begin
            wait_room(200);
            pulse(rand_line());
        end
        drain(0, 1000);
        chk("wrap_packets", 32'(pkt_cnt - base), 32'd257);

        // Drop counter saturation
        reset_pulse();
        out_ready = 1'b0;
        @(posedge clk); #2; print_line = rand_line(); print_line_ready = 1'b1;
        repeat (4 + 65534) @(posedge clk);
        #2; print_line_ready = 1'b0;
        @(negedge clk);
        chk("sat_fffe", 32'(overflow_count), 32'hFFFE);
        @(posedge clk); #2; print_line_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2; print_line_ready = 1'b0;
        @(negedge clk);
        chk("sat_ffff", 32'(overflow_count), 32'hFFFF);
        chk("sat_pending", 32'(lines_pending), 32'd4);
        drain(0, 400);

        // Reset in the middle of a packet
        out_ready = 1'b1;
        pulse(rand_line());
        base = xfer_cnt;
        cyc = 0;
        while (xfer_cnt < base + 11 && cyc < 100) begin
            @(posedge clk); #2;
            cyc++;
        end
        chk("midrst_reached", 32'(xfer_cnt - base >= 11), 32'd1);
        reset_pulse();
        @(negedge clk);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_pending", 32'(lines_pending), 32'd0);
        chk("midrst_ovf", 32'(overflow_count), 32'd0);
        pulse(rand_line());
        drain(0, 200);

        // Final report
        @(negedge clk);
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail + 1);
        $fatal(1, "time limit");
    end

endmodule
